// File: rtl/cpu_sequencer.sv
// Multi-cycle CPU control sequencer: FETCH/DECODE/EXEC/MEM/WB with
// memory wait timeout, retired-instruction counting and a sticky error state.
module cpu_sequencer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] instr_rdata,
  input  logic        imem_ack,
  input  logic        load,
  input  logic        store,
  input  logic        branch,
  input  logic        jal,
  input  logic        jalr,
  input  logic        reg_write,
  input  logic        branch_taken,
  input  logic        dmem_ack,
  output logic        imem_req,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] ir,
  output logic        pc_we,
  output logic [1:0]  pc_sel,
  output logic        rf_we,
  output logic [2:0]  state,
  output logic [31:0] instret,
  output logic        err
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_ERR    = 3'd6
  } state_t;

  state_t      r_state;
  logic [3:0]  r_wait;
  logic [31:0] r_ir;
  logic [31:0] r_instret;
  logic        r_imem_req;
  logic        r_dmem_req;
  logic        r_dmem_we;
  logic        r_pc_we;
  logic [1:0]  r_pc_sel;
  logic        r_rf_we;
  logic        r_err;

  logic [1:0]  w_pc_sel;
  logic        w_wb_rf_we;

  always_comb begin
    w_pc_sel = 2'b00;
    if (jal)                        w_pc_sel = 2'b01;
    else if (jalr)                  w_pc_sel = 2'b10;
    else if (branch & branch_taken) w_pc_sel = 2'b01;
    w_wb_rf_we = reg_write | load;
  end

  // Outputs are registered for the state being entered, so WB strobes are
  // loaded on the edge into WB and cleared by default on every other edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_wait     <= '0;
      r_ir       <= '0;
      r_instret  <= '0;
      r_imem_req <= 1'b0;
      r_dmem_req <= 1'b0;
      r_dmem_we  <= 1'b0;
      r_pc_we    <= 1'b0;
      r_pc_sel   <= 2'b00;
      r_rf_we    <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_pc_we  <= 1'b0;
      r_pc_sel <= 2'b00;
      r_rf_we  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state    <= S_FETCH;
            r_wait     <= '0;
            r_imem_req <= 1'b1;
          end
        end
        S_FETCH: begin
          if (imem_ack) begin
            r_ir       <= instr_rdata;
            r_state    <= S_DECODE;
            r_imem_req <= 1'b0;
          end else if (r_wait == 4'd15) begin
            r_state    <= S_ERR;
            r_imem_req <= 1'b0;
            r_err      <= 1'b1;
          end else begin
            r_wait <= r_wait + 4'd1;
          end
        end
        S_DECODE: r_state <= S_EXEC;
        S_EXEC: begin
          if (load | store) begin
            r_state    <= S_MEM;
            r_wait     <= '0;
            r_dmem_req <= 1'b1;
            r_dmem_we  <= store;
          end else begin
            r_state  <= S_WB;
            r_pc_we  <= 1'b1;
            r_pc_sel <= w_pc_sel;
            r_rf_we  <= w_wb_rf_we;
          end
        end
        S_MEM: begin
          if (dmem_ack) begin
            r_state    <= S_WB;
            r_dmem_req <= 1'b0;
            r_dmem_we  <= 1'b0;
            r_pc_we    <= 1'b1;
            r_pc_sel   <= w_pc_sel;
            r_rf_we    <= w_wb_rf_we;
          end else if (r_wait == 4'd15) begin
            r_state    <= S_ERR;
            r_dmem_req <= 1'b0;
            r_dmem_we  <= 1'b0;
            r_err      <= 1'b1;
          end else begin
            r_wait <= r_wait + 4'd1;
          end
        end
        S_WB: begin
          r_instret  <= r_instret + 32'd1;
          r_state    <= S_FETCH;
          r_wait     <= '0;
          r_imem_req <= 1'b1;
        end
        S_ERR:   r_state <= S_ERR;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign state    = r_state;
  assign ir       = r_ir;
  assign instret  = r_instret;
  assign imem_req = r_imem_req;
  assign dmem_req = r_dmem_req;
  assign dmem_we  = r_dmem_we;
  assign pc_we    = r_pc_we;
  assign pc_sel   = r_pc_sel;
  assign rf_we    = r_rf_we;
  assign err      = r_err;

endmodule
